// File: rtl/axis_rr_arbiter_if.sv
// AXI4-Stream bundle used between the arbiter and the downstream byte FIFO.
// The master drives payload and valid; the slave returns ready.
interface my_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_IN AXI4-Stream sources onto one sink.
// A grant is held from the first beat through the accepted tlast beat.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant; pick the next requester after last_ptr
// ST_PASS | granted stream passed through until its tlast handshake
module axis_rr_arbiter #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int CNT_W  = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [N_IN*DATA_W-1:0]    s_tdata,
  input  logic [N_IN*KEEP_W-1:0]    s_tkeep,
  input  logic [N_IN-1:0]           s_tlast,
  input  logic [N_IN-1:0]           s_tvalid,
  output logic [N_IN-1:0]           s_tready,
  my_axis_if.master                 m_axis,
  output logic [$clog2(N_IN)-1:0]   StatusGrant,
  output logic                      StatusBusy,
  output logic [CNT_W-1:0]          StatusPktCnt
);

  localparam int GRANT_W = $clog2(N_IN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  logic [0:0]         state;
  logic [GRANT_W-1:0] grant;
  logic [GRANT_W-1:0] last_ptr;
  logic [GRANT_W-1:0] next_grant;
  logic [GRANT_W-1:0] cand;
  logic               req_found;
  logic               pass_en;
  logic               pkt_done;

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    next_grant = '0;
    req_found  = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N_IN; k++) begin
      cand = GRANT_W'((int'(last_ptr) + k) % N_IN);
      if (!req_found && s_tvalid[cand]) begin
        next_grant = cand;
        req_found  = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while Rst is high so no beat can be lost to a reset edge.
  assign pass_en = (state == ST_PASS) && !Rst;

  always_comb begin
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tlast  = 1'b0;
    m_axis.tvalid = 1'b0;
    s_tready      = '0;
    if (pass_en) begin
      m_axis.tdata    = s_tdata[grant*DATA_W +: DATA_W];
      m_axis.tkeep    = s_tkeep[grant*KEEP_W +: KEEP_W];
      m_axis.tlast    = s_tlast[grant];
      m_axis.tvalid   = s_tvalid[grant];
      s_tready[grant] = m_axis.tready;
    end
  end

  assign pkt_done = pass_en && s_tvalid[grant] && s_tlast[grant] && m_axis.tready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ST_IDLE;
      last_ptr     <= GRANT_W'(N_IN - 1);
      grant        <= '0;
      StatusPktCnt <= '0;
    end else if (state == ST_IDLE) begin
      if (req_found) begin
        grant <= next_grant;
        state <= ST_PASS;
      end
    end else begin
      if (pkt_done) begin
        last_ptr     <= grant;
        StatusPktCnt <= StatusPktCnt + 1'b1;
        state        <= ST_IDLE;
      end
    end
  end

  assign StatusGrant = grant;
  assign StatusBusy  = (state == ST_PASS);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: two sources fed from beat tables, sink beats logged
// at the falling edge and compared with hand-computed sequences.
module tb_axis_rr_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] s_tdata;
  logic [1:0]  s_tkeep;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tready;
  logic [0:0]  StatusGrant;
  logic        StatusBusy;
  logic [3:0]  StatusPktCnt;

  always #5 Clk = ~Clk;

  my_axis_if #(.DATA_W(8), .KEEP_W(1)) m_if ();

  axis_rr_arbiter #(.N_IN(2), .DATA_W(8), .KEEP_W(1), .CNT_W(4)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_axis       (m_if.master),
    .StatusGrant  (StatusGrant),
    .StatusBusy   (StatusBusy),
    .StatusPktCnt (StatusPktCnt)
  );

  logic [8:0] mem [2][64];
  int         rd [2];
  int         wr [2];
  logic [1:0] src_en;
  logic [8:0] outq [64];
  int         out_n;
  int         total = 0;
  int         bad = 0;

  task automatic drive_srcs();
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i]      = src_en[i] && (rd[i] != wr[i]);
      s_tdata[i*8 +: 8] = mem[i][rd[i]][7:0];
      s_tlast[i]       = mem[i][rd[i]][8] && s_tvalid[i];
      s_tkeep[i]       = 1'b1;
    end
  endtask

  task automatic cycle();
    logic [1:0] fire;
    @(negedge Clk);
    fire = s_tvalid & s_tready;
    if (m_if.tvalid && m_if.tready && out_n < 64) begin
      outq[out_n] = {m_if.tlast, m_if.tdata};
      out_n++;
    end
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) if (fire[i]) rd[i]++;
    drive_srcs();
    #1;
  endtask

  task automatic push_pkt(input int src, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      mem[src][wr[src]] = {(b == n - 1), base + 8'(b)};
      wr[src]++;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    src_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    out_n = 0;
    m_if.tready = 1'b1;
    drive_srcs();
    cycle();
    cycle();
    Rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (StatusBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", StatusBusy); end
    total++; if (StatusPktCnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", StatusPktCnt); end
    total++; if (StatusGrant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", StatusGrant); end
    total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL reset_sready got=%b exp=00", s_tready); end
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", m_if.tvalid); end
  endtask

  task automatic test_single_stream();
    logic [8:0] exp [3];
    exp = '{9'h0A0, 9'h0A1, 9'h1A2};
    do_reset();
    push_pkt(1, 8'hA0, 3);
    src_en = 2'b10;
    drive_srcs();
    #1;
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL single_idle_mvalid got=%b exp=0", m_if.tvalid); end
    cycle();
    total++; if (StatusGrant !== 1'b1) begin bad++; $display("FAIL single_grant got=%0d exp=1", StatusGrant); end
    total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL single_sready got=%b exp=10", s_tready); end
    for (int b = 0; b < 3; b++) begin
      total++; if (m_if.tdata !== 8'hA0 + 8'(b)) begin bad++; $display("FAIL single_beat%0d got=%h exp=%h", b, m_if.tdata, 8'hA0 + 8'(b)); end
      cycle();
    end
    total++; if (StatusBusy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", StatusBusy); end
    total++; if (StatusPktCnt !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", StatusPktCnt); end
    total++; if (StatusGrant !== 1'b1) begin bad++; $display("FAIL single_grant_hold got=%0d exp=1", StatusGrant); end
    total++; if (out_n !== 3) begin bad++; $display("FAIL single_nbeats got=%0d exp=3", out_n); end
    for (int b = 0; b < 3; b++) begin
      total++; if (outq[b] !== exp[b]) begin bad++; $display("FAIL single_out%0d got=%h exp=%h", b, outq[b], exp[b]); end
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp [8];
    exp = '{9'h000, 9'h101, 9'h010, 9'h111, 9'h002, 9'h103, 9'h012, 9'h113};
    do_reset();
    push_pkt(0, 8'h00, 2);
    push_pkt(0, 8'h02, 2);
    push_pkt(1, 8'h10, 2);
    push_pkt(1, 8'h12, 2);
    src_en = 2'b11;
    drive_srcs();
    #1;
    for (int c = 0; c < 12; c++) cycle();
    total++; if (StatusPktCnt !== 4'd4) begin bad++; $display("FAIL rr_cnt got=%0d exp=4", StatusPktCnt); end
    total++; if (out_n !== 8) begin bad++; $display("FAIL rr_nbeats got=%0d exp=8", out_n); end
    for (int b = 0; b < 8; b++) begin
      total++; if (outq[b] !== exp[b]) begin bad++; $display("FAIL rr_out%0d got=%h exp=%h", b, outq[b], exp[b]); end
    end
  endtask

  task automatic test_mid_request();
    logic [8:0] exp [5];
    exp = '{9'h020, 9'h021, 9'h122, 9'h030, 9'h131};
    do_reset();
    push_pkt(0, 8'h20, 3);
    src_en = 2'b01;
    drive_srcs();
    #1;
    cycle();
    push_pkt(1, 8'h30, 2);
    src_en = 2'b11;
    drive_srcs();
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (s_tready !== 2'b01) begin bad++; $display("FAIL mid_sready%0d got=%b exp=01", c, s_tready); end
      cycle();
    end
    total++; if (StatusBusy !== 1'b0) begin bad++; $display("FAIL mid_idle_busy got=%b exp=0", StatusBusy); end
    total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL mid_idle_sready got=%b exp=00", s_tready); end
    cycle();
    total++; if (StatusGrant !== 1'b1) begin bad++; $display("FAIL mid_grant1 got=%0d exp=1", StatusGrant); end
    total++; if (m_if.tdata !== 8'h30) begin bad++; $display("FAIL mid_first_s1 got=%h exp=30", m_if.tdata); end
    cycle();
    cycle();
    total++; if (out_n !== 5) begin bad++; $display("FAIL mid_nbeats got=%0d exp=5", out_n); end
    for (int b = 0; b < 5; b++) begin
      total++; if (outq[b] !== exp[b]) begin bad++; $display("FAIL mid_out%0d got=%h exp=%h", b, outq[b], exp[b]); end
    end
  endtask

  task automatic test_backpressure();
    logic       pat [6];
    logic [8:0] exp [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp = '{9'h040, 9'h041, 9'h042, 9'h143};
    do_reset();
    push_pkt(0, 8'h40, 4);
    src_en = 2'b01;
    drive_srcs();
    #1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      m_if.tready = pat[k];
      #1;
      total++; if (s_tready !== {1'b0, pat[k]}) begin bad++; $display("FAIL bp_sready%0d got=%b exp=%b", k, s_tready, {1'b0, pat[k]}); end
      total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_mvalid%0d got=%b exp=1", k, m_if.tvalid); end
      cycle();
    end
    m_if.tready = 1'b1;
    total++; if (StatusPktCnt !== 4'd1) begin bad++; $display("FAIL bp_cnt got=%0d exp=1", StatusPktCnt); end
    total++; if (out_n !== 4) begin bad++; $display("FAIL bp_nbeats got=%0d exp=4", out_n); end
    for (int b = 0; b < 4; b++) begin
      total++; if (outq[b] !== exp[b]) begin bad++; $display("FAIL bp_out%0d got=%h exp=%h", b, outq[b], exp[b]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [8:0] exp [6];
    exp = '{9'h15F, 9'h050, 9'h051, 9'h052, 9'h153, 9'h160};
    do_reset();
    push_pkt(0, 8'h5F, 1);
    push_pkt(0, 8'h50, 4);
    src_en = 2'b01;
    drive_srcs();
    #1;
    for (int c = 0; c < 4; c++) cycle();
    total++; if (m_if.tdata !== 8'h51) begin bad++; $display("FAIL rstmid_pending got=%h exp=51", m_if.tdata); end
    total++; if (StatusPktCnt !== 4'd1) begin bad++; $display("FAIL rstmid_cnt_pre got=%0d exp=1", StatusPktCnt); end
    push_pkt(1, 8'h60, 1);
    src_en = 2'b11;
    Rst = 1'b1;
    drive_srcs();
    #1;
    total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL rstmid_sready_in_rst got=%b exp=00", s_tready); end
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_mvalid_in_rst got=%b exp=0", m_if.tvalid); end
    cycle();
    Rst = 1'b0;
    #1;
    total++; if (StatusBusy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", StatusBusy); end
    total++; if (StatusPktCnt !== 4'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", StatusPktCnt); end
    total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL rstmid_sready got=%b exp=00", s_tready); end
    cycle();
    total++; if (StatusGrant !== 1'b0) begin bad++; $display("FAIL rstmid_regrant got=%0d exp=0", StatusGrant); end
    total++; if (m_if.tdata !== 8'h51) begin bad++; $display("FAIL rstmid_resume got=%h exp=51", m_if.tdata); end
    for (int c = 0; c < 5; c++) cycle();
    total++; if (StatusPktCnt !== 4'd2) begin bad++; $display("FAIL rstmid_cnt_post got=%0d exp=2", StatusPktCnt); end
    total++; if (out_n !== 6) begin bad++; $display("FAIL rstmid_nbeats got=%0d exp=6", out_n); end
    for (int b = 0; b < 6; b++) begin
      total++; if (outq[b] !== exp[b]) begin bad++; $display("FAIL rstmid_out%0d got=%h exp=%h", b, outq[b], exp[b]); end
    end
  endtask

  task automatic test_cnt_wrap();
    logic [7:0] exp_d;
    do_reset();
    for (int p = 0; p < 9; p++) push_pkt(0, 8'h70 + 8'(p), 1);
    for (int p = 0; p < 8; p++) push_pkt(1, 8'h80 + 8'(p), 1);
    src_en = 2'b11;
    drive_srcs();
    #1;
    for (int p = 0; p < 17; p++) begin
      exp_d = ((p % 2) == 0) ? 8'h70 + 8'(p / 2) : 8'h80 + 8'(p / 2);
      cycle();
      total++; if (StatusGrant !== 1'(p % 2)) begin bad++; $display("FAIL wrap_grant%0d got=%0d exp=%0d", p, StatusGrant, p % 2); end
      total++; if (m_if.tdata !== exp_d) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", p, m_if.tdata, exp_d); end
      cycle();
      total++; if (StatusPktCnt !== 4'((p + 1) % 16)) begin bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", p, StatusPktCnt, (p + 1) % 16); end
    end
  endtask

  initial begin
    m_if.tready = 1'b1;
    src_en = 2'b00;
    out_n = 0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    drive_srcs();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_mid_request();
    test_backpressure();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
